fpdiv_arbiter: RTL and testbench

FPDIV_ARBITER -- requirements
Module: fpdiv_arbiter

---
 rtl/fpdiv_arbiter_if.sv | 25 ++
 rtl/fpdiv_arbiter.sv | 113 +++++++++++
 tb/tb_fpdiv_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fpdiv_arbiter_if.sv
// fpdiv_arbiter_if: requester-side and divider-side signals of the shared divider arbiter.
interface fpdiv_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]    req_i;
  logic [32*N_REQ-1:0] dividend_i;
  logic [32*N_REQ-1:0] divisor_i;
  logic [N_REQ-1:0]    gnt_o;
  logic [N_REQ-1:0]    done_o;
  logic                err_o;
  logic [31:0]         result_o;
  logic                div_start_o;
  logic [31:0]         div_dividend_o;
  logic [31:0]         div_divisor_o;
  logic                div_busy_i;
  logic                div_valid_i;
  logic                div_error_i;
  logic [31:0]         div_result_i;
  modport slave (
    input  req_i, dividend_i, divisor_i, div_busy_i, div_valid_i, div_error_i, div_result_i,
    output gnt_o, done_o, err_o, result_o, div_start_o, div_dividend_o, div_divisor_o
  );
  modport master (
    output req_i, dividend_i, divisor_i, div_busy_i, div_valid_i, div_error_i, div_result_i,
    input  gnt_o, done_o, err_o, result_o, div_start_o, div_dividend_o, div_divisor_o
  );
endinterface

// File: rtl/fpdiv_arbiter.sv
// fpdiv_arbiter: round-robin arbiter sharing one single-precision divider among N_REQ requesters.
module fpdiv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 63
) (
  input logic           clk_i,
  input logic           rst_i,
  fpdiv_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d, sel;
  logic [IW:0]     rr;
  logic            any;
  logic [31:0]     dvd_q, dvd_d, dvs_q, dvs_d, res_q, res_d, sel_dvd, sel_dvs;
  logic            err_q, err_d, ld_q, ld_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            unused_busy;
  assign unused_busy = bus.div_busy_i;
  // scan from one above the last grant; lowest offset wins because it is visited last
  always_comb begin
    sel = '0;
    any = 1'b0;
    rr  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      rr = {1'b0, ptr_q} + (IW+1)'(i);
      rr = (rr >= (IW+1)'(N_REQ)) ? rr - (IW+1)'(N_REQ) : rr;
      if (bus.req_i[rr[IW-1:0]]) begin
        sel = rr[IW-1:0];
        any = 1'b1;
      end
    end
  end
  assign sel_dvd = bus.dividend_i[{sel, 5'd0} +: 32];
  assign sel_dvs = bus.divisor_i[{sel, 5'd0} +: 32];
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    err_d   = err_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (any) begin
        ptr_d   = sel;
        idx_d   = sel;
        dvd_d   = sel_dvd;
        dvs_d   = sel_dvs;
        ld_d    = 1'b0;
        res_d   = '0;
        err_d   = (sel_dvs == 32'h0);
        state_d = (sel_dvs == 32'h0) ? DONE : LOAD;
      end
      LOAD: begin
        ld_d    = 1'b1;
        state_d = ld_q ? START : LOAD;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.div_valid_i) begin
          res_d   = bus.div_result_i;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (bus.div_error_i || cnt_q + 8'd1 == 8'(TIMEOUT)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      idx_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end
  // gnt is combinational in IDLE so the grant and operand capture share one cycle
  assign bus.gnt_o          = (state_q == IDLE && any && !rst_i) ? {{(N_REQ-1){1'b0}}, 1'b1} << sel : '0;
  assign bus.done_o         = (state_q == DONE) ? {{(N_REQ-1){1'b0}}, 1'b1} << idx_q : '0;
  assign bus.err_o          = (state_q == DONE) && err_q;
  assign bus.result_o       = (state_q == DONE) ? res_q : 32'h0;
  assign bus.div_start_o    = (state_q == START);
  assign bus.div_dividend_o = dvd_q;
  assign bus.div_divisor_o  = dvs_q;
endmodule

// File: tb/tb_fpdiv_arbiter.sv
// tb_fpdiv_arbiter: scoreboard bench with a behavioural divider for fpdiv_arbiter.
module tb_fpdiv_arbiter;
  localparam int N = 4;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  fpdiv_arbiter_if #(.N_REQ(N)) bus();
  fpdiv_arbiter #(.N_REQ(N), .TIMEOUT(63)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  typedef struct {int idx; logic err; logic [31:0] res; int lat;} exp_t;
  exp_t        dq[$];
  int          gq[$];
  int          errors = 0, checks = 0, cyc = 0, gcyc = 0, starts = 0, dcnt = 0, dv_lat = 0, s0 = 0;
  logic        dv_err = 1'b0;
  logic [31:0] dv_res = '0;
  exp_t        mx;
  int          mg;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial forever @(posedge clk_i) cyc++;
  // divider model: valid (or error) dv_lat cycles after the start pulse, never when dv_lat is 0
  initial begin
    bus.div_valid_i  = 1'b0;
    bus.div_error_i  = 1'b0;
    bus.div_busy_i   = 1'b0;
    bus.div_result_i = '0;
    forever @(negedge clk_i) begin
      bus.div_valid_i = 1'b0;
      bus.div_error_i = 1'b0;
      if (rst_i) begin
        dcnt = 0;
        bus.div_busy_i = 1'b0;
      end else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            bus.div_busy_i = 1'b0;
            if (dv_err) bus.div_error_i = 1'b1;
            else begin
              bus.div_valid_i  = 1'b1;
              bus.div_result_i = dv_res;
            end
          end
        end
        if (bus.div_start_o) begin
          starts++;
          if (dv_lat > 0) begin
            dcnt = dv_lat;
            bus.div_busy_i = 1'b1;
          end
        end
      end
    end
  end
  initial forever @(negedge clk_i) if (!rst_i) begin
    if (|bus.gnt_o) begin
      if (gq.size() == 0) chk("gnt_unexpected", 32'(bus.gnt_o), 32'd0);
      else begin
        mg = gq.pop_front();
        chk("gnt", 32'(bus.gnt_o), 32'd1 << mg);
        chk("gnt_with_done", 32'(bus.done_o), 32'd0);
        gcyc = cyc;
      end
    end
    if (|bus.done_o) begin
      if (dq.size() == 0) chk("done_unexpected", 32'(bus.done_o), 32'd0);
      else begin
        mx = dq.pop_front();
        chk("done", 32'(bus.done_o), 32'd1 << mx.idx);
        chk("err", 32'(bus.err_o), 32'(mx.err));
        chk("result", bus.result_o, mx.res);
        chk("latency", 32'(cyc - gcyc), 32'(mx.lat));
      end
    end
  end
  task automatic set_slice(input int k, input logic [31:0] a, input logic [31:0] b);
    bus.dividend_i[32*k +: 32] = a;
    bus.divisor_i[32*k +: 32]  = b;
  endtask
  task automatic expect_txn(input int k, input logic e, input logic [31:0] r, input int lat);
    exp_t x;
    x.idx = k; x.err = e; x.res = r; x.lat = lat;
    dq.push_back(x);
    gq.push_back(k);
  endtask
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b, input int lat,
                       input logic derr, input logic [31:0] dres,
                       input logic eerr, input logic [31:0] eres, input int elat);
    dv_lat = lat; dv_err = derr; dv_res = dres;
    expect_txn(k, eerr, eres, elat);
    @(posedge clk_i); #1;
    set_slice(k, a, b);
    bus.req_i[k] = 1'b1;
  endtask
  task automatic wait_done(input int k, input int budget);
    int n = 0;
    do begin @(negedge clk_i); n++; end while (!bus.done_o[k] && n < budget);
    if (!bus.done_o[k]) chk($sformatf("done%0d_wait", k), 32'(bus.done_o[k]), 32'd1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.req_i = '0;
    bus.dividend_i = '0;
    bus.divisor_i = '0;
    for (int k = 0; k < N; k++) set_slice(k, 32'h3F800000, 32'h40000000);
    bus.req_i = '1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_start", 32'(bus.div_start_o), 32'd0);
    chk("rst_dividend", bus.div_dividend_o, 32'd0);
    chk("rst_divisor", bus.div_divisor_o, 32'd0);
    // fairness: all four held, 1.0/2.0 with divider valid 2 cycles after start
    dv_lat = 2; dv_err = 1'b0; dv_res = 32'h3F000000;
    for (int t = 0; t < 5; t++) expect_txn(t % N, 1'b0, 32'h3F000000, 6);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int t = 0; t < 5; t++) wait_done(t % N, 20);
    bus.req_i = '0;
    repeat (3) @(negedge clk_i);
    issue(0, 32'h40C00000, 32'h40000000, 24, 1'b0, 32'h40400000, 1'b0, 32'h40400000, 28);
    wait_done(0, 60);
    bus.req_i = '0;
    s0 = starts;
    issue(2, 32'h3F800000, 32'h00000000, 5, 1'b0, 32'h12345678, 1'b1, 32'h0, 1);
    wait_done(2, 10);
    bus.req_i = '0;
    repeat (3) @(negedge clk_i);
    chk("zero_div_no_start", 32'(starts), 32'(s0));
    issue(1, 32'h3F800000, 32'h40400000, 4, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0, 8);
    wait_done(1, 20);
    bus.req_i = '0;
    // timeout with the request dropped right after its grant
    issue(3, 32'h40000000, 32'h3F800000, 0, 1'b0, 32'h0, 1'b1, 32'h0, 67);
    @(posedge clk_i); #1;
    bus.req_i[3] = 1'b0;
    wait_done(3, 100);
    repeat (2) @(negedge clk_i);
    issue(0, 32'h40C00000, 32'h40000000, 0, 1'b0, 32'h0, 1'b1, 32'h0, 67);
    repeat (10) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("arst_done", 32'(bus.done_o), 32'd0);
    chk("arst_err", 32'(bus.err_o), 32'd0);
    chk("arst_result", bus.result_o, 32'd0);
    chk("arst_start", 32'(bus.div_start_o), 32'd0);
    chk("arst_dividend", bus.div_dividend_o, 32'd0);
    chk("arst_divisor", bus.div_divisor_o, 32'd0);
    dq.delete();
    gq.delete();
    bus.req_i = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      chk("arst_no_done", 32'(bus.done_o), 32'd0);
    end
    issue(0, 32'h40C00000, 32'h40400000, 5, 1'b0, 32'h40000000, 1'b0, 32'h40000000, 9);
    wait_done(0, 30);
    bus.req_i = '0;
    // operand stability: requester 1 rewrites its slice after the grant
    issue(1, 32'h3F800000, 32'h40800000, 3, 1'b0, 32'h3E800000, 1'b0, 32'h3E800000, 7);
    @(posedge clk_i); #1;
    set_slice(1, 32'hFFFFFFFF, 32'h12345678);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      chk("hold_dividend", bus.div_dividend_o, 32'h3F800000);
      chk("hold_divisor", bus.div_divisor_o, 32'h40800000);
    end while (!bus.done_o[1] && n < 20);
    chk("hold_done", 32'(bus.done_o[1]), 32'd1);
    bus.req_i = '0;
    repeat (5) @(negedge clk_i);
    chk("scoreboard_drained", 32'(dq.size() + gq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
